// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_pkg
// Brief  : 640x480@60 timing constants and the one-hot sync-phase encoding
//          used by both the horizontal and vertical timing stages.
// Rev    : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

    localparam int C_H_PULSE  = 96;
    localparam int C_H_BP     = 48;
    localparam int C_H_ACTIVE = 640;
    localparam int C_H_FP     = 16;
    localparam int C_H_TOTAL      = C_H_PULSE + C_H_BP + C_H_ACTIVE + C_H_FP;
    localparam int C_H_BLANK_END  = C_H_PULSE + C_H_BP;
    localparam int C_H_ACTIVE_END = C_H_BLANK_END + C_H_ACTIVE;

    localparam int C_V_PULSE  = 2;
    localparam int C_V_BP     = 33;
    localparam int C_V_ACTIVE = 480;
    localparam int C_V_FP     = 10;
    localparam int C_V_TOTAL      = C_V_PULSE + C_V_BP + C_V_ACTIVE + C_V_FP;
    localparam int C_V_BLANK_END  = C_V_PULSE + C_V_BP;
    localparam int C_V_ACTIVE_END = C_V_BLANK_END + C_V_ACTIVE;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_SP   = 5'b00010,
        ST_BP   = 5'b00100,
        ST_AP   = 5'b01000,
        ST_FP   = 5'b10000
    } timing_state_t;

endpackage
`default_nettype wire

// File: rtl/pix_clk_en.sv
`default_nettype none
// ============================================================================
// Module : pix_clk_en
// Brief  : Divides the system clock into a registered one-clk pixel enable.
// Rev    : 1.0  initial release
// ============================================================================
module pix_clk_en #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_en
);

    localparam int C_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(CLK_DIV - 1);

    logic [C_DIV_W-1:0] r_div_cnt;
    logic               r_pix_en;
    logic               w_wrap;

    assign w_wrap = (r_div_cnt == C_DIV_LAST);
    assign pix_en = r_pix_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_pix_en  <= 1'b0;
        end else begin
            r_div_cnt <= w_wrap ? '0 : r_div_cnt + 1'b1;
            r_pix_en  <= w_wrap;
        end
    end

endmodule
`default_nettype wire

// File: rtl/h_sync_gen.sv
`default_nettype none
// ============================================================================
// Module : h_sync_gen
// Brief  : Horizontal VGA timing: pixel counter, sync/porch/active phases,
//          active-low hsync, data enable, active column and line-end pulse.
// Rev    : 1.0  initial release
// ============================================================================
module h_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int PULSE_LENGTH = C_H_PULSE,
    parameter int BACK_PORCH   = C_H_BP,
    parameter int ACTIVE_VIDEO = C_H_ACTIVE,
    parameter int FRONT_PORCH  = C_H_FP
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic       hsync,
    output logic       h_de,
    output logic [9:0] pixcel_col,
    output logic       line_end
);

    localparam int C_TOTAL = PULSE_LENGTH + BACK_PORCH + ACTIVE_VIDEO + FRONT_PORCH;
    localparam logic [9:0] C_LAST       = 10'(C_TOTAL - 1);
    localparam logic [9:0] C_SP_END     = 10'(PULSE_LENGTH);
    localparam logic [9:0] C_BLANK_END  = 10'(PULSE_LENGTH + BACK_PORCH);
    localparam logic [9:0] C_ACTIVE_END = 10'(PULSE_LENGTH + BACK_PORCH + ACTIVE_VIDEO);

    logic          w_pix_en;
    logic [9:0]    r_count_h;
    logic [9:0]    w_count_nxt;
    timing_state_t r_state;
    timing_state_t w_state_nxt;
    logic          r_hsync;
    logic          r_h_de;
    logic [9:0]    r_col;
    logic          r_line_end;

    pix_clk_en #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_clk_en (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_en (w_pix_en)
    );

    // IDLE holds the counter at 0 so the first sync pulse is full width.
    always_comb begin
        w_count_nxt = r_count_h + 10'd1;
        if (r_state == ST_IDLE || r_count_h == C_LAST) begin
            w_count_nxt = '0;
        end
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_SP;
            ST_SP:   w_state_nxt = (w_count_nxt == C_SP_END)     ? ST_BP : ST_SP;
            ST_BP:   w_state_nxt = (w_count_nxt == C_BLANK_END)  ? ST_AP : ST_BP;
            ST_AP:   w_state_nxt = (w_count_nxt == C_ACTIVE_END) ? ST_FP : ST_AP;
            ST_FP:   w_state_nxt = (w_count_nxt == 10'd0)        ? ST_SP : ST_FP;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count_h  <= '0;
            r_state    <= ST_IDLE;
            r_hsync    <= 1'b1;
            r_h_de     <= 1'b0;
            r_col      <= '0;
            r_line_end <= 1'b0;
        end else begin
            r_line_end <= w_pix_en && (w_state_nxt != ST_IDLE) && (w_count_nxt == C_LAST);
            if (w_pix_en) begin
                r_count_h <= w_count_nxt;
                r_state   <= w_state_nxt;
                r_hsync   <= (w_state_nxt != ST_SP);
                r_h_de    <= (w_state_nxt == ST_AP);
                r_col     <= (w_state_nxt == ST_AP) ? (w_count_nxt - C_BLANK_END) : 10'd0;
            end
        end
    end

    assign pix_en     = w_pix_en;
    assign hsync      = r_hsync;
    assign h_de       = r_h_de;
    assign pixcel_col = r_col;
    assign line_end   = r_line_end;

endmodule
`default_nettype wire

// File: tb/tb_h_sync_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_h_sync_gen
// Brief  : Self-checking bench for h_sync_gen (default VGA and tiny timing).
// Rev    : 1.0  initial release
// ============================================================================
module tb_h_sync_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         n;
    int         errors = 0;
    int         checks = 0;
    bit         pin_phase = 1'b1;

    logic       a_pe, a_hs, a_de, a_le;
    logic [9:0] a_col;
    logic       b_pe, b_hs, b_de, b_le;
    logic [9:0] b_col;

    always #5 clk = ~clk;

    h_sync_gen #(
        .CLK_DIV(2), .PULSE_LENGTH(96), .BACK_PORCH(48), .ACTIVE_VIDEO(640), .FRONT_PORCH(16)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .pix_en(a_pe), .hsync(a_hs),
        .h_de(a_de), .pixcel_col(a_col), .line_end(a_le)
    );

    h_sync_gen #(
        .CLK_DIV(1), .PULSE_LENGTH(2), .BACK_PORCH(3), .ACTIVE_VIDEO(4), .FRONT_PORCH(1)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .pix_en(b_pe), .hsync(b_hs),
        .h_de(b_de), .pixcel_col(b_col), .line_end(b_le)
    );

    // Rising clock edges seen since the last reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (n=%0d t=%0t)", nm, act, exp, n, $time);
        end
    endtask

    // Expected outputs after e clock edges since release, from the timing rules.
    function automatic void model(input int cdiv, input int pl, input int bp, input int av,
                                  input int fp, input int e, input bit run,
                                  output bit pe, output bit hs, output bit de,
                                  output bit le, output int col);
        int tot;
        int p;
        int c;
        tot = pl + bp + av + fp;
        pe = 1'b0; hs = 1'b1; de = 1'b0; le = 1'b0; col = 0;
        if (!run || e == 0) return;
        pe = ((e % cdiv) == 0);
        p  = (e - 1) / cdiv;
        if (p == 0) return;
        c   = (p - 1) % tot;
        hs  = (c >= pl);
        de  = (c >= pl + bp) && (c < pl + bp + av);
        col = de ? c - pl - bp : 0;
        le  = (((e - 1) % cdiv) == 0) && (c == tot - 1);
    endfunction

    always @(negedge clk) begin : cmp
        bit pe, hs, de, le;
        int col;
        model(2, 96, 48, 640, 16, n, rst_n, pe, hs, de, le, col);
        chk("a_pix_en", a_pe, pe);
        chk("a_hsync", a_hs, hs);
        chk("a_h_de", a_de, de);
        chk("a_col", a_col, col);
        chk("a_line_end", a_le, le);
        model(1, 2, 3, 4, 1, n, rst_n, pe, hs, de, le, col);
        chk("b_pix_en", b_pe, pe);
        chk("b_hsync", b_hs, hs);
        chk("b_h_de", b_de, de);
        chk("b_col", b_col, col);
        chk("b_line_end", b_le, le);
        if (pin_phase && rst_n) begin
            case (n)
                2:    begin chk("pin_a_hs_n2", a_hs, 1); chk("pin_b_hs_fall", b_hs, 0); end
                3:    begin chk("pin_a_hs_fall", a_hs, 0); chk("pin_b_hs_n3", b_hs, 0); end
                4:    begin chk("pin_a_pe_n4", a_pe, 1); chk("pin_b_hs_rise", b_hs, 1); end
                5:    chk("pin_a_pe_n5", a_pe, 0);
                7:    begin chk("pin_b_de_rise", b_de, 1); chk("pin_b_col0", b_col, 0); end
                10:   chk("pin_b_col3", b_col, 3);
                11:   begin chk("pin_b_de_fall", b_de, 0); chk("pin_b_le", b_le, 1); end
                12:   chk("pin_b_hs_fall2", b_hs, 0);
                194:  chk("pin_a_hs_last_low", a_hs, 0);
                195:  chk("pin_a_hs_rise", a_hs, 1);
                290:  chk("pin_a_de_pre", a_de, 0);
                291:  begin chk("pin_a_de_rise", a_de, 1); chk("pin_a_col0", a_col, 0); end
                293:  chk("pin_a_col1", a_col, 1);
                1569: chk("pin_a_col639", a_col, 639);
                1571: begin chk("pin_a_de_fall", a_de, 0); chk("pin_a_col_after", a_col, 0); end
                1601: chk("pin_a_le", a_le, 1);
                1602: begin chk("pin_a_le_clear", a_le, 0); chk("pin_a_hs_pre2", a_hs, 1); end
                1603: chk("pin_a_hs_fall2", a_hs, 0);
                3203: chk("pin_a_hs_fall3", a_hs, 0);
                default: ;
            endcase
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_a_hs"}, a_hs, 1);
        chk({tag, "_a_de"}, a_de, 0);
        chk({tag, "_a_col"}, a_col, 0);
        chk({tag, "_a_pe"}, a_pe, 0);
        chk({tag, "_a_le"}, a_le, 0);
        chk({tag, "_b_hs"}, b_hs, 1);
        chk({tag, "_b_de"}, b_de, 0);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3400) @(negedge clk);
        pin_phase = 1'b0;

        // Reset in the middle of the active region (column 400).
        guard = 0;
        while (a_col != 10'd400 && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_col400_bound", int'(guard < 4000), 1);
        #2 rst_n = 1'b0;
        #1 reset_checks("midline_rst");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2000) @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            repeat ($urandom_range(1, 3000)) @(negedge clk);
            #2 rst_n = 1'b0;
            #1 reset_checks("rand_rst");
            repeat ($urandom_range(1, 4)) @(negedge clk);
            #2 rst_n = 1'b1;
        end
        repeat (1700) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
